// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester round-robin arbiter for the register file write port
//
// Purpose: shares the register file's single write port between r0 (ALU
// writeback) and r1 (load/debug path). Grants are combinational and
// round-robin on conflict. The granted write is registered into
// rf_write/rf_addr/rf_wdata one cycle later. Read-after-write hazards are
// flagged for decode, and cycles with both requesters contending are counted.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   hold                blocks new grants; an already captured write still issues
//   r0_* / r1_*         valid/addr/data in, ready out (ready = accepted this cycle)
//   rd_addr1, rd_addr2  decode-stage read addresses checked for hazards
//   raw_stall           read-after-write hazard against the write stage or this cycle's grant
//   rf_write/addr/wdata registered write port into the register file
//   conflict_cnt        saturating count of cycles with both requesters valid and not held
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              raw_stall,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Index of the requester granted on the most recent transfer; the other
  // requester wins the next tie.
  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;
  logic              rf_write_q;
  logic              contend;
  logic              wr_hit;
  logic              xfer_hit;

  // Grants only go to valid requesters, so a grant is a transfer.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && !hold) begin
      if (r0_valid && r1_valid) begin
        if (last_grant) grant0 = 1'b1;
        else            grant1 = 1'b1;
      end else if (r0_valid) begin
        grant0 = 1'b1;
      end else if (r1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign r0_ready   = grant0;
  assign r1_ready   = grant1;
  assign xfer       = grant0 | grant1;
  assign grant_addr = grant1 ? r1_addr : r0_addr;
  assign grant_data = grant1 ? r1_data : r0_data;
  assign contend    = r0_valid & r1_valid & ~hold;

  // A write captured just before reset is dropped: the write enable is
  // masked while reset is high, then cleared by the reset edge.
  assign rf_write = rf_write_q & ~reset;

  assign wr_hit    = rf_write & ((rf_addr == rd_addr1) | (rf_addr == rd_addr2));
  assign xfer_hit  = xfer & ((grant_addr == rd_addr1) | (grant_addr == rd_addr2));
  assign raw_stall = wr_hit | xfer_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_q   <= 1'b0;
      rf_addr      <= '0;
      rf_wdata     <= '0;
      last_grant   <= 1'b1;
      conflict_cnt <= '0;
    end else begin
      rf_write_q <= xfer;
      if (xfer) begin
        rf_addr    <= grant_addr;
        rf_wdata   <= grant_data;
        last_grant <= grant1;
      end
      if (contend && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
